// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: one saturating outstanding-write counter per
// architectural register, with reserve from ID, two writeback release ports and flush.
module rf_scoreboard #(
  parameter int W_RD  = 3,
  parameter int W_CNT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rsv_v_i,
  input  logic [W_RD-1:0] rsv_name_i,
  input  logic            rel0_v_i,
  input  logic [W_RD-1:0] rel0_name_i,
  input  logic            rel1_v_i,
  input  logic [W_RD-1:0] rel1_name_i,
  input  logic            flush_i,
  input  logic [W_RD-1:0] rd_name_i,
  input  logic [W_RD-1:0] rs_name_i,
  output logic            rd_reserved_o,
  output logic            rs_reserved_o,
  output logic            rsv_full_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int NREG = 1 << W_RD;
  // Two extra bits so cnt + 1 and the two-port release sum never overflow.
  localparam int CW   = W_CNT + 2;
  localparam logic [W_CNT-1:0] MAXCNT = '1;

  logic [W_CNT-1:0] cnt_q [NREG];
  logic [W_CNT-1:0] cnt_d [NREG];
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             rsv_acc;

  assign rd_reserved_o = (cnt_q[rd_name_i] != '0);
  assign rs_reserved_o = (cnt_q[rs_name_i] != '0);
  assign rsv_full_o    = (cnt_q[rsv_name_i] == MAXCNT);
  assign rsv_acc       = rsv_v_i & ~rsv_full_o & ~flush_i;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

  always_comb begin
    logic          hit0, hit1;
    logic [CW-1:0] cur, rel, inc, dec, nxt;
    // NOTE: every variable gets a default before any conditional use so no latch is inferred.
    err_d  = err_q;
    busy_d = 1'b0;
    hit0   = 1'b0;
    hit1   = 1'b0;
    cur    = '0;
    rel    = '0;
    inc    = '0;
    dec    = '0;
    nxt    = '0;
    for (int r = 0; r < NREG; r++) begin
      hit0 = rel0_v_i & ~flush_i & (rel0_name_i == W_RD'(r));
      hit1 = rel1_v_i & ~flush_i & (rel1_name_i == W_RD'(r));
      cur  = CW'(cnt_q[r]);
      rel  = CW'(hit0) + CW'(hit1);
      inc  = CW'(rsv_acc & (rsv_name_i == W_RD'(r)));
      // Releases are judged against the pre-update count; any excess is an error.
      dec  = (rel > cur) ? cur : rel;
      if (rel > cur) err_d = 1'b1;
      nxt  = cur + inc - dec;
      cnt_d[r] = flush_i ? '0 : W_CNT'(nxt);
      busy_d   = busy_d | (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the counter array is reset explicitly; stale reservations would stall issue forever.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed scenarios then random traffic, all checked
// against a per-register count model built from the scoreboard rules.
module tb_rf_scoreboard;

  localparam int W_RD  = 3;
  localparam int W_CNT = 2;
  localparam int NREG  = 1 << W_RD;
  localparam int MAXC  = (1 << W_CNT) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            rsv_v_i;
  logic [W_RD-1:0] rsv_name_i;
  logic            rel0_v_i;
  logic [W_RD-1:0] rel0_name_i;
  logic            rel1_v_i;
  logic [W_RD-1:0] rel1_name_i;
  logic            flush_i;
  logic [W_RD-1:0] rd_name_i;
  logic [W_RD-1:0] rs_name_i;
  logic            rd_reserved_o;
  logic            rs_reserved_o;
  logic            rsv_full_o;
  logic            busy_o;
  logic            err_o;

  int n_vec = 0;
  int n_mis = 0;

  int m_cnt [NREG];
  bit m_err;

  rf_scoreboard #(.W_RD(W_RD), .W_CNT(W_CNT)) dut (
    .clk           (clk),
    .rst           (rst),
    .rsv_v_i       (rsv_v_i),
    .rsv_name_i    (rsv_name_i),
    .rel0_v_i      (rel0_v_i),
    .rel0_name_i   (rel0_name_i),
    .rel1_v_i      (rel1_v_i),
    .rel1_name_i   (rel1_name_i),
    .flush_i       (flush_i),
    .rd_name_i     (rd_name_i),
    .rs_name_i     (rs_name_i),
    .rd_reserved_o (rd_reserved_o),
    .rs_reserved_o (rs_reserved_o),
    .rsv_full_o    (rsv_full_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge: each release consumes one outstanding
  // write from the count held before the edge; the reservation is then added.
  task automatic model_edge(input bit rv, input int rn, input bit r0v, input int r0n,
                            input bit r1v, input int r1n, input bit fl, input bit rs_n);
    int avail [NREG];
    if (!rs_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (fl) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      avail = m_cnt;
      if (r0v) begin
        if (avail[r0n] > 0) avail[r0n]--; else m_err = 1'b1;
      end
      if (r1v) begin
        if (avail[r1n] > 0) avail[r1n]--; else m_err = 1'b1;
      end
      if (rv && m_cnt[rn] < MAXC) avail[rn]++;
      m_cnt = avail;
    end
  endtask

  function automatic bit model_busy();
    foreach (m_cnt[i]) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs at the falling edge, check outputs, then advance one edge.
  task automatic step(input bit rv, input int rn, input bit r0v, input int r0n,
                      input bit r1v, input int r1n, input bit fl,
                      input int rd, input int rs, input bit rs_n = 1'b1);
    @(negedge clk);
    rsv_v_i     = rv;
    rsv_name_i  = rn[W_RD-1:0];
    rel0_v_i    = r0v;
    rel0_name_i = r0n[W_RD-1:0];
    rel1_v_i    = r1v;
    rel1_name_i = r1n[W_RD-1:0];
    flush_i     = fl;
    rd_name_i   = rd[W_RD-1:0];
    rs_name_i   = rs[W_RD-1:0];
    rst         = rs_n;
    #1;
    check("rd_reserved", rd_reserved_o, m_cnt[rd] != 0);
    check("rs_reserved", rs_reserved_o, m_cnt[rs] != 0);
    check("rsv_full",    rsv_full_o,    m_cnt[rn] == MAXC);
    check("busy",        busy_o,        model_busy());
    check("err",         err_o,         m_err);
    @(posedge clk);
    model_edge(rv, rn, r0v, r0n, r1v, r1n, fl, rs_n);
  endtask

  task automatic idle(input int rd, input int rs);
    step(1'b0, rd, 1'b0, 0, 1'b0, 0, 1'b0, rd, rs);
  endtask

  initial begin
    rst = 1'b0; rsv_v_i = 1'b0; rsv_name_i = '0; rel0_v_i = 1'b0; rel0_name_i = '0;
    rel1_v_i = 1'b0; rel1_name_i = '0; flush_i = 1'b0; rd_name_i = '0; rs_name_i = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then reserve r3 and release it.
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 3, 1'b0);
    step(1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0, 3, 0);
    step(1'b0, 0, 1'b1, 3, 1'b0, 0, 1'b0, 3, 0);
    idle(3, 3);

    // Saturate r5, attempt a fourth reservation, then drain.
    repeat (3) step(1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0, 0, 5);
    step(1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0, 0, 5);
    check("r5_full_after_refused", rsv_full_o, 1'b1);
    step(1'b0, 5, 1'b1, 5, 1'b0, 0, 1'b0, 0, 5);
    step(1'b0, 5, 1'b0, 0, 1'b1, 5, 1'b0, 0, 5);
    step(1'b0, 5, 1'b1, 5, 1'b0, 0, 1'b0, 0, 5);
    idle(5, 5);

    // Same-cycle reserve and release of r2 holding one write.
    step(1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0, 2, 2);
    step(1'b1, 2, 1'b0, 0, 1'b1, 2, 1'b0, 2, 2);
    idle(2, 2);
    check("r2_still_reserved", rd_reserved_o, 1'b1);
    step(1'b0, 0, 1'b1, 2, 1'b0, 0, 1'b0, 2, 2);

    // Dual release of r4 at count 2, then at count 1 (error).
    repeat (2) step(1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0, 4, 4);
    step(1'b0, 0, 1'b1, 4, 1'b1, 4, 1'b0, 4, 4);
    step(1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0, 4, 4);
    step(1'b0, 0, 1'b1, 4, 1'b1, 4, 1'b0, 4, 4);
    idle(4, 4);
    check("err_dual_release", err_o, 1'b1);

    // Flush with a simultaneous reservation of r7.
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0, 1, 6);
    step(1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0, 1, 6);
    step(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b1, 1, 6);
    idle(7, 1);
    check("busy_after_flush", busy_o, 1'b0);

    // Release of unreserved r0: sticky through flush, cleared by reset.
    step(1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 0);
    idle(0, 0);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 0);
    idle(0, 0);
    check("err_sticky_flush", err_o, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    idle(0, 0);
    check("err_cleared_by_reset", err_o, 1'b0);

    // Random traffic over a narrow name range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, NREG - 1),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
           $urandom_range(0, 63) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter W_RD, default 3, meaning register-name width; NREG = 2^W_RD registers tracked.
REQ-002 SHALL have parameter W_CNT, default 2, meaning per-register outstanding-write counter width; MAXCNT = 2^W_CNT - 1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rsv_v_i  input  1  ID requests reservation of rsv_name_i.
REQ-006 SHALL have port rsv_name_i  input  W_RD  register to reserve.
REQ-007 SHALL have ports rel0_v_i / rel1_v_i  input  1 each  writeback release strobes (port 0 = ALU WB, port 1 = load WB).
REQ-008 SHALL have ports rel0_name_i / rel1_name_i  input  W_RD each  register released.
REQ-009 SHALL have port flush_i  input  1  clear all reservations (branch redirect).
REQ-010 SHALL have ports rd_name_i / rs_name_i  input  W_RD each  query names from ID.
REQ-011 SHALL have ports rd_reserved_o / rs_reserved_o  output  1 each  queried register has outstanding write(s).
REQ-012 SHALL have port rsv_full_o  output  1  rsv_name_i counter at MAXCNT; reservation refused.
REQ-013 SHALL have port busy_o  output  1  any counter nonzero.
REQ-014 SHALL have port err_o  output  1  sticky error: release of a zero counter seen.

Function
REQ-015 SHALL hold one W_CNT-bit counter cnt[r] per register r.
REQ-016 SHALL compute rd_reserved_o = (cnt[rd_name_i] != 0) and rs_reserved_o = (cnt[rs_name_i] != 0) combinationally from registered state (no same-cycle release bypass).
REQ-017 SHALL compute rsv_full_o = (cnt[rsv_name_i] == MAXCNT) combinationally.
REQ-018 SHALL accept a reservation when rsv_v_i & ~rsv_full_o & ~flush_i; a refused reservation changes no state.
REQ-019 SHALL accept release on port k when relk_v_i & ~flush_i & cnt[relk_name_i] != 0.
REQ-020 SHALL, per register, apply next cnt = cnt + (accepted reservations to r) - (accepted releases to r), net of all three ports in one cycle; no wrap past 0 or MAXCNT.
REQ-021 SHALL, when both release ports name the same register, decrement by 2 if cnt >= 2; if cnt == 1, decrement by 1 and set err_o.
REQ-022 SHALL, on release to a zero counter, leave counter at 0 and set err_o on the next edge.
REQ-023 SHALL, with reservation and release to the same register in one cycle, keep the counter unchanged (release judged against the pre-update count).
REQ-024 SHALL, on flush_i, set all counters to 0 at the next edge, ignoring same-cycle reservations and releases; err_o unaffected.
REQ-025 SHALL register busy_o as OR of next-state counters, so busy_o reflects state one cycle after the update.
REQ-026 SHALL keep err_o set until reset.
REQ-027 SHALL have single-cycle latency: reserve/release at edge N is visible on rd/rs_reserved_o after edge N.

Reset
REQ-028 SHALL, when rst == 0 at posedge clk, clear all counters, busy_o and err_o; rd_reserved_o, rs_reserved_o and rsv_full_o then read 0.
REQ-029 SHALL give reset priority over flush, reservation and release; reset mid-operation discards all outstanding reservations.

Verification
REQ-030 SHALL cover: reset, then rsv r3 -> next cycle rd_name_i=3 gives rd_reserved_o=1, busy_o=1; rel0 r3 -> next cycle 0, busy_o=0.
REQ-031 SHALL cover: rsv r5 three times (W_CNT=2) -> rsv_full_o=1; fourth rsv refused, cnt stays 3; three releases -> rs_reserved_o=0.
REQ-032 SHALL cover: cnt[2]=1, same-cycle rsv r2 and rel1 r2 -> cnt[2] stays 1, rd_reserved_o=1, err_o=0.
REQ-033 SHALL cover: cnt[4]=2, rel0 and rel1 both r4 -> cnt 0; repeat with cnt[4]=1 -> cnt 0, err_o=1.
REQ-034 SHALL cover: r1, r6 reserved, flush_i with simultaneous rsv r7 -> all counters 0, busy_o=0, r7 not reserved.
REQ-035 SHALL cover: release of unreserved r0 -> err_o=1 sticky through flush, cleared only by rst=0.
